sobel_window_gen: RTL and testbench

//  Builds 3x3 pixel neighbourhoods from a raster-order grayscale pixel stream.

---
 rtl/gray_sobel_pkg.sv | 20 ++
 rtl/sobel_line_buffer.sv | 29 ++
 rtl/sobel_window_gen.sv | 132 +++++++++++++
 tb/tb_sobel_window_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gray_sobel_pkg.sv
// Shared types for the grayscale -> Sobel pipeline.
//   PIXEL_WIDTH : default grayscale pixel width
//   pixel_t     : one grayscale pixel
//   window_t    : 3x3 neighbourhood, slot k = 3*row + col
//   win_state_t : window-generator frame FSM states
package gray_sobel_pkg;

  localparam int unsigned PIXEL_WIDTH = 8;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;
  typedef pixel_t [8:0]           window_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DONE
  } win_state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of pixel storage, read and written at the same column.
//   clk       : clock
//   wr_en     : write wr_data at addr on the rising edge
//   addr      : column index shared by read and write
//   wr_data   : pixel to store
//   rd_data_c : combinational read of the value stored before this edge
module sobel_line_buffer #(
  parameter  int unsigned PIXEL_WIDTH = 8,
  parameter  int unsigned IMG_WIDTH   = 16,
  localparam int unsigned ADDR_W      = $clog2(IMG_WIDTH)
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [PIXEL_WIDTH-1:0] wr_data,
  output logic [PIXEL_WIDTH-1:0] rd_data_c
);

  logic [PIXEL_WIDTH-1:0] mem [IMG_WIDTH];

  // Contents are intentionally not reset; they are refilled every frame.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

  // Read-before-write: the old entry is visible during the writing cycle.
  assign rd_data_c = mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Builds 3x3 neighbourhoods from a raster-order grayscale pixel stream.
//   clk_i        : clock
//   reset_i      : synchronous active-high reset
//   start_i      : frame start pulse; clears counters and arms the block
//   px_rdy_i     : px_i valid this cycle
//   px_i         : grayscale pixel, raster order
//   win_o        : 3x3 window, slot k = 3*row+col at [k*PW +: PW]
//   win_rdy_o    : win_o valid strobe
//   frame_done_o : one-cycle pulse after the last frame pixel
//   busy_o       : high from start_i until frame_done_o
module sobel_window_gen #(
  parameter int unsigned PIXEL_WIDTH = gray_sobel_pkg::PIXEL_WIDTH,
  parameter int unsigned IMG_WIDTH   = 16,
  parameter int unsigned IMG_HEIGHT  = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic                     px_rdy_i,
  input  logic [PIXEL_WIDTH-1:0]   px_i,
  output logic [9*PIXEL_WIDTH-1:0] win_o,
  output logic                     win_rdy_o,
  output logic                     frame_done_o,
  output logic                     busy_o
);

  import gray_sobel_pkg::*;

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  win_state_t             state, next_state;
  logic [COL_W-1:0]       col, col_d;
  logic [ROW_W-1:0]       row, row_d;
  logic [PIXEL_WIDTH-1:0] win_q [9];
  logic [PIXEL_WIDTH-1:0] win_d [9];
  logic [9*PIXEL_WIDTH-1:0] win_flat;
  logic [PIXEL_WIDTH-1:0] rb0_rd, rb1_rd;
  logic                   accept, last_px, win_valid;

  // rb0 holds row r-1, rb1 holds row r-2 at the current column.
  sobel_line_buffer #(.PIXEL_WIDTH(PIXEL_WIDTH), .IMG_WIDTH(IMG_WIDTH)) u_rowbuf0 (
    .clk       (clk_i),
    .wr_en     (accept),
    .addr      (col),
    .wr_data   (px_i),
    .rd_data_c (rb0_rd)
  );

  sobel_line_buffer #(.PIXEL_WIDTH(PIXEL_WIDTH), .IMG_WIDTH(IMG_WIDTH)) u_rowbuf1 (
    .clk       (clk_i),
    .wr_en     (accept),
    .addr      (col),
    .wr_data   (rb0_rd),
    .rd_data_c (rb1_rd)
  );

  // Next-state, counters and window shift.
  always_comb begin
    next_state = state;
    col_d      = col;
    row_d      = row;
    win_d      = win_q;
    win_flat   = '0;

    // start_i wins over a coincident pixel strobe.
    accept    = px_rdy_i && !start_i && ((state == FILL) || (state == STREAM));
    last_px   = (row == ROW_W'(IMG_HEIGHT - 1)) && (col == COL_W'(IMG_WIDTH - 1));
    win_valid = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));

    unique case (state)
      IDLE:   ;
      FILL: begin
        if (accept && last_px)                                   next_state = DONE;
        else if (accept && row == ROW_W'(2) && col == COL_W'(2)) next_state = STREAM;
      end
      STREAM: if (accept && last_px) next_state = DONE;
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (start_i) next_state = FILL;

    if (start_i) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col == COL_W'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = last_px ? '0 : row + ROW_W'(1);
      end else begin
        col_d = col + COL_W'(1);
      end
    end

    // Shift left; the new right column is rows r-2, r-1, r.
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = rb1_rd;
      win_d[5] = rb0_rd;
      win_d[8] = px_i;
    end

    for (int k = 0; k < 9; k++) win_flat[k*PIXEL_WIDTH +: PIXEL_WIDTH] = win_d[k];
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      win_o        <= '0;
      win_rdy_o    <= 1'b0;
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      state        <= next_state;
      col          <= col_d;
      row          <= row_d;
      win_q        <= win_d;
      win_rdy_o    <= win_valid;
      if (win_valid) win_o <= win_flat;
      frame_done_o <= (state == DONE) && !start_i;
      busy_o       <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 4x4 frame, pixel value off+4*r+c.
module tb_sobel_window_gen;

  localparam int unsigned PW = 8;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;

  logic            clk = 1'b0;
  logic            reset_i, start_i, px_rdy_i;
  logic [PW-1:0]   px_i;
  logic [9*PW-1:0] win_o;
  logic            win_rdy_o, frame_done_o, busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int win_seen = 0;

  logic [9*PW-1:0] exp_win_q[$];
  int              exp_due_q[$];
  int              done_q[$];

  sobel_window_gen #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .px_rdy_i     (px_rdy_i),
    .px_i         (px_i),
    .win_o        (win_o),
    .win_rdy_o    (win_rdy_o),
    .frame_done_o (frame_done_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Window whose bottom-right pixel is (r,c) in a frame with values off+4*r+c.
  function automatic logic [9*PW-1:0] exp_window(input int off, input int r, input int c);
    logic [9*PW-1:0] w;
    w = '0;
    for (int wr = 0; wr < 3; wr++)
      for (int wc = 0; wc < 3; wc++)
        w[(3*wr+wc)*PW +: PW] = PW'(off + 4*(r-2+wr) + (c-2+wc));
    return w;
  endfunction

  // Output monitor: compares every strobe against the scoreboard.
  always @(negedge clk) begin
    if (win_rdy_o === 1'b1) begin
      win_seen++;
      if (exp_win_q.size() == 0) begin
        check("unexpected_win_rdy", 72'(win_rdy_o), 72'(0));
      end else begin
        check("win_data", win_o, exp_win_q.pop_front());
        check("win_latency", 72'(cyc), 72'(exp_due_q.pop_front()));
      end
    end
    if (frame_done_o === 1'b1) begin
      if (done_q.size() == 0) begin
        check("unexpected_frame_done", 72'(frame_done_o), 72'(0));
      end else begin
        check("done_cycle", 72'(cyc), 72'(done_q.pop_front()));
        check("busy_low_at_done", 72'(busy_o), 72'(0));
      end
    end
  end

  task automatic do_start();
    start_i  = 1'b1;
    px_rdy_i = 1'b1;      // must be ignored alongside start
    px_i     = 8'hAA;
    tick();
    start_i  = 1'b0;
    px_rdy_i = 1'b0;
    check("busy_after_start", 72'(busy_o), 72'(1));
  endtask

  // Sends pixels 0..last_idx with up to gmax idle cycles after each.
  task automatic send_frame(input int off, input int gmax, input int last_idx);
    for (int idx = 0; idx <= last_idx; idx++) begin
      int r, c;
      r = idx / 4;
      c = idx % 4;
      px_rdy_i = 1'b1;
      px_i     = PW'(off + idx);
      if (r >= 2 && c >= 2) begin
        exp_win_q.push_back(exp_window(off, r, c));
        exp_due_q.push_back(cyc + 1);
      end
      if (idx == 15) done_q.push_back(cyc + 2);
      tick();
      px_rdy_i = 1'b0;
      repeat ($urandom_range(gmax, 0)) tick();
    end
  endtask

  task automatic settle_and_check(input string tag, input int n_win);
    repeat (4) tick();
    check({tag, "_win_count"}, 72'(win_seen), 72'(n_win));
    check({tag, "_busy_idle"}, 72'(busy_o), 72'(0));
    check({tag, "_queue_empty"}, 72'(exp_win_q.size() + done_q.size()), 72'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs.
    reset_i = 1'b1; start_i = 1'b0; px_rdy_i = 1'b0; px_i = '0;
    repeat (3) begin
      start_i  = 1'($urandom);
      px_rdy_i = 1'($urandom);
      px_i     = PW'($urandom);
      tick();
    end
    check("rst_win", win_o, 72'(0));
    check("rst_win_rdy", 72'(win_rdy_o), 72'(0));
    check("rst_done", 72'(frame_done_o), 72'(0));
    check("rst_busy", 72'(busy_o), 72'(0));
    reset_i = 1'b0; start_i = 1'b0; px_rdy_i = 1'b0;
    tick();

    // Back-to-back frame.
    win_seen = 0;
    do_start();
    send_frame(0, 0, 15);
    settle_and_check("b2b", 4);
    check("win_hold_last", win_o, exp_window(0, 3, 3));

    // Same frame with random idle gaps.
    win_seen = 0;
    do_start();
    send_frame(0, 3, 15);
    settle_and_check("gaps", 4);

    // Pixels while idle (after frame_done) must be ignored.
    win_seen = 0;
    for (int i = 0; i < 8; i++) begin
      px_rdy_i = 1'b1;
      px_i     = PW'(i);
      tick();
      check("idle_busy", 72'(busy_o), 72'(0));
    end
    px_rdy_i = 1'b0;
    settle_and_check("idle", 0);

    // Restart mid-frame after pixel 6, then a full new frame.
    win_seen = 0;
    do_start();
    send_frame(0, 0, 6);
    do_start();
    send_frame(16, 2, 15);
    settle_and_check("restart", 4);

    // Reset after pixel 11, then a full frame.
    win_seen = 0;
    do_start();
    send_frame(0, 0, 11);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("midrst_win", win_o, 72'(0));
    check("midrst_win_rdy", 72'(win_rdy_o), 72'(0));
    check("midrst_busy", 72'(busy_o), 72'(0));
    check("midrst_windows_before", 72'(win_seen), 72'(2));
    win_seen = 0;
    do_start();
    send_frame(32, 3, 15);
    settle_and_check("post_rst", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
